// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants and Dadda height helpers for the mantissa multiplier
package mul_pkg;

  localparam int FP16_MANT_W = 11;
  localparam int FP32_MANT_W = 24;

  // d_0 = 2, d_{j+1} = floor(1.5 * d_j): 2,3,4,6,9,13,19,28,...
  function automatic int dadda_height(input int j);
    int d;
    d = 2;
    for (int k = 0; k < 16; k++) begin
      if (k < j) d = d + d / 2;
    end
    return d;
  endfunction

  function automatic int dadda_stages(input int width);
    int n;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      if (dadda_height(k) < width) n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/dadda_reduce.sv
// rtl/dadda_reduce.sv - combinational Dadda tree reducing WIDTH x WIDTH partial products to two rows
module dadda_reduce
  import mul_pkg::*;
#(
  parameter int WIDTH = FP16_MANT_W
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-2:0] row0_o,
  output logic [2*WIDTH-2:0] row1_o
);
  localparam int COLS = 2 * WIDTH - 1;
  localparam int H    = WIDTH + 1;
  localparam int NST  = dadda_stages(WIDTH);

  always_comb begin : tree
    logic [H-1:0] cur  [COLS];
    logic [H-1:0] nxt  [COLS];
    int           cnt  [COLS];
    int           ncnt [COLS];
    int           d, idx, rem;
    logic         x, y, z, s, cy;
    for (int i = 0; i < COLS; i++) begin
      cur[i] = '0; nxt[i] = '0; cnt[i] = 0; ncnt[i] = 0;
    end
    d = 0; idx = 0; rem = 0;
    x = 1'b0; y = 1'b0; z = 1'b0; s = 1'b0; cy = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        cur[i+j][cnt[i+j]] = a_i[i] & b_i[j];
        cnt[i+j] = cnt[i+j] + 1;
      end
    end
    // Each stage brings every column (own bits + carries in) down to d_j.
    for (int st = NST - 1; st >= 0; st--) begin
      d = dadda_height(st);
      for (int i = 0; i < COLS; i++) begin
        nxt[i] = '0; ncnt[i] = 0;
      end
      for (int i = 0; i < COLS; i++) begin
        idx = 0;
        for (int r = 0; r < H; r++) begin
          rem = cnt[i] - idx + ncnt[i];
          if (rem > d && cnt[i] - idx >= 2) begin
            x = cur[i][idx];
            y = cur[i][idx+1];
            if (rem == d + 1 || cnt[i] - idx == 2) begin
              s = x ^ y; cy = x & y; idx = idx + 2;
            end else begin
              z = cur[i][idx+2];
              s = x ^ y ^ z; cy = (x & y) | (x & z) | (y & z); idx = idx + 3;
            end
            nxt[i][ncnt[i]] = s;
            ncnt[i] = ncnt[i] + 1;
            if (i + 1 < COLS) begin
              nxt[i+1][ncnt[i+1]] = cy;
              ncnt[i+1] = ncnt[i+1] + 1;
            end
          end
        end
        for (int r = 0; r < H; r++) begin
          if (r >= idx && r < cnt[i]) begin
            nxt[i][ncnt[i]] = cur[i][r];
            ncnt[i] = ncnt[i] + 1;
          end
        end
      end
      cur = nxt;
      cnt = ncnt;
    end
    for (int i = 0; i < COLS; i++) begin
      row0_o[i] = cur[i][0];
      row1_o[i] = cur[i][1];
    end
  end

endmodule

// File: rtl/ksa.sv
// rtl/ksa.sv - Kogge-Stone adder, BITS wide with carry in and carry out
module ksa #(
  parameter int BITS = 21
) (
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  input  logic            cin_i,
  output logic [BITS-1:0] sum_o,
  output logic            cout_o
);
  localparam int LV = $clog2(BITS);

  always_comb begin : prefix
    logic [BITS-1:0] g [LV+1];
    logic [BITS-1:0] p [LV+1];
    logic [BITS:0]   c;
    for (int l = 0; l <= LV; l++) begin
      g[l] = '0;
      p[l] = '0;
    end
    g[0] = a_i & b_i;
    p[0] = a_i ^ b_i;
    for (int l = 0; l < LV; l++) begin
      for (int i = 0; i < BITS; i++) begin
        if (i >= (1 << l)) begin
          g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
          p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
        end else begin
          g[l+1][i] = g[l][i];
          p[l+1][i] = p[l][i];
        end
      end
    end
    // After the last level g/p span bits [i:0], so carry-in folds in directly.
    c = '0;
    c[0] = cin_i;
    for (int i = 0; i < BITS; i++) begin
      c[i+1] = g[LV][i] | (p[LV][i] & cin_i);
    end
    sum_o  = p[0] ^ c[BITS-1:0];
    cout_o = c[BITS];
  end

endmodule

// File: rtl/dadda_mul_pipe.sv
// rtl/dadda_mul_pipe.sv - two-stage unsigned multiplier with valid/ready, tag sideband and flush
module dadda_mul_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH = FP16_MANT_W,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   in_a_i,
  input  logic [WIDTH-1:0]   in_b_i,
  input  logic [TAG_W-1:0]   in_tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] out_prod_o,
  output logic               out_msb_o,
  output logic [TAG_W-1:0]   out_tag_o
);
  localparam int RW = 2 * WIDTH - 1;

  logic [RW-1:0]      row0_d, row1_d, row0_q, row1_q, sum;
  logic               cout;
  logic [2*WIDTH-1:0] prod_d, prod_q;
  logic [TAG_W-1:0]   tag1_q, tag2_q;
  logic               v1_d, v1_q, v2_d, v2_q;
  logic               adv2, rdy, ld1, ld2;

  dadda_reduce #(.WIDTH(WIDTH)) u_reduce (
    .a_i    (in_a_i),
    .b_i    (in_b_i),
    .row0_o (row0_d),
    .row1_o (row1_d)
  );

  ksa #(.BITS(RW)) u_ksa (
    .a_i    (row0_q),
    .b_i    (row1_q),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout)
  );

  assign prod_d = {cout, sum};

  always_comb begin
    adv2 = !v2_q | out_ready_i;
    rdy  = !v1_q | adv2;
    v1_d = v1_q;
    v2_d = v2_q;
    if (flush_i) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else begin
      if (adv2) v2_d = v1_q;
      if (rdy)  v1_d = in_valid_i;
    end
    // Bubbles and flushes leave the data registers untouched.
    ld1 = !flush_i & rdy & in_valid_i;
    ld2 = !flush_i & adv2 & v1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      row0_q <= '0;
      row1_q <= '0;
      tag1_q <= '0;
      prod_q <= '0;
      tag2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (ld1) begin
        row0_q <= row0_d;
        row1_q <= row1_d;
        tag1_q <= in_tag_i;
      end
      if (ld2) begin
        prod_q <= prod_d;
        tag2_q <= tag1_q;
      end
    end
  end

  assign in_ready_o  = rdy;
  assign out_valid_o = v2_q;
  assign out_prod_o  = prod_q;
  assign out_msb_o   = prod_q[2*WIDTH-1];
  assign out_tag_o   = tag2_q;

endmodule

// File: tb/tb_dadda_mul_pipe.sv
// tb/tb_dadda_mul_pipe.sv - self-checking bench: queue model plus directed literal vectors
module tb_dadda_mul_pipe;
  localparam int W  = 11;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, m_flush, m_iv, m_ir, m_or, m_ov, m_msb;
  logic [W-1:0] m_a, m_b;
  logic [TW-1:0] m_tag, m_otag;
  logic [2*W-1:0] m_prod;

  logic x_iv;
  logic [31:0] x_a, x_b;
  logic [TW-1:0] x_tag;
  logic x4_ir, x4_v, x4_m, x24_ir, x24_v, x24_m, x32_ir, x32_v, x32_m;
  logic [7:0] x4_p;
  logic [47:0] x24_p;
  logic [63:0] x32_p;
  logic [TW-1:0] x4_t, x24_t, x32_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_out = 0;

  dadda_mul_pipe #(.WIDTH(W), .TAG_W(TW)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(m_flush), .in_valid_i(m_iv), .in_ready_o(m_ir),
    .in_a_i(m_a), .in_b_i(m_b), .in_tag_i(m_tag), .out_valid_o(m_ov), .out_ready_i(m_or),
    .out_prod_o(m_prod), .out_msb_o(m_msb), .out_tag_o(m_otag));

  dadda_mul_pipe #(.WIDTH(4), .TAG_W(TW)) u_w4 (
    .clk(clk), .rst_n(rst_n), .flush_i(1'b0), .in_valid_i(x_iv), .in_ready_o(x4_ir),
    .in_a_i(x_a[3:0]), .in_b_i(x_b[3:0]), .in_tag_i(x_tag), .out_valid_o(x4_v), .out_ready_i(1'b1),
    .out_prod_o(x4_p), .out_msb_o(x4_m), .out_tag_o(x4_t));

  dadda_mul_pipe #(.WIDTH(24), .TAG_W(TW)) u_w24 (
    .clk(clk), .rst_n(rst_n), .flush_i(1'b0), .in_valid_i(x_iv), .in_ready_o(x24_ir),
    .in_a_i(x_a[23:0]), .in_b_i(x_b[23:0]), .in_tag_i(x_tag), .out_valid_o(x24_v), .out_ready_i(1'b1),
    .out_prod_o(x24_p), .out_msb_o(x24_m), .out_tag_o(x24_t));

  dadda_mul_pipe #(.WIDTH(32), .TAG_W(TW)) u_w32 (
    .clk(clk), .rst_n(rst_n), .flush_i(1'b0), .in_valid_i(x_iv), .in_ready_o(x32_ir),
    .in_a_i(x_a), .in_b_i(x_b), .in_tag_i(x_tag), .out_valid_o(x32_v), .out_ready_i(1'b1),
    .out_prod_o(x32_p), .out_msb_o(x32_m), .out_tag_o(x32_t));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mulw(input int w, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] aa, bb;
    aa = {32'b0, a};
    bb = {32'b0, b};
    if (w < 32) begin
      aa = aa & ((64'd1 << w) - 64'd1);
      bb = bb & ((64'd1 << w) - 64'd1);
    end
    return aa * bb;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: FIFO of accepted operations; an op may be presented once it is two cycles old.
  typedef struct { logic [63:0] p; logic [TW-1:0] t; int acc; } ment_t;
  ment_t mq[$];
  bit stall_q = 0, flush_prev = 0;
  logic [2*W-1:0] held_p;
  logic [TW-1:0] held_t;

  always @(negedge clk) begin : mon
    ment_t e;
    logic ev;
    if (!rst_n) begin
      mq.delete();
      stall_q = 0;
      flush_prev = 0;
    end else begin
      ev = 1'b0;
      if (mq.size() > 0) ev = (cyc - mq[0].acc >= 2);
      chk("out_valid", 64'(m_ov), 64'(ev));
      chk("in_ready", 64'(m_ir), 64'((mq.size() < 2) || m_or));
      if (stall_q && !flush_prev) begin
        chk("hold_prod", 64'(m_prod), 64'(held_p));
        chk("hold_tag", 64'(m_otag), 64'(held_t));
      end
      if (m_ov && m_or && mq.size() > 0) begin
        e = mq.pop_front();
        chk("prod", 64'(m_prod), e.p);
        chk("msb", 64'(m_msb), 64'(e.p[2*W-1]));
        chk("tag", 64'(m_otag), 64'(e.t));
        n_out++;
      end
      if (m_flush) mq.delete();
      else if (m_iv && m_ir) begin
        e.p = {53'b0, m_a} * {53'b0, m_b};
        e.t = m_tag;
        e.acc = cyc;
        mq.push_back(e);
      end
      stall_q = m_ov && !m_or;
      held_p = m_prod;
      held_t = m_otag;
      flush_prev = m_flush;
    end
  end

  typedef struct { logic [31:0] a; logic [31:0] b; logic [TW-1:0] t; int acc; } xent_t;
  xent_t xq[$];

  always @(negedge clk) begin : xmon
    xent_t e;
    logic ev;
    logic [63:0] p4, p24, p32;
    if (!rst_n) xq.delete();
    else begin
      ev = 1'b0;
      if (xq.size() > 0) ev = (cyc - xq[0].acc >= 2);
      chk("w4_valid", 64'(x4_v), 64'(ev));
      chk("w24_valid", 64'(x24_v), 64'(ev));
      chk("w32_valid", 64'(x32_v), 64'(ev));
      if (ev) begin
        e = xq.pop_front();
        p4 = mulw(4, e.a, e.b);
        p24 = mulw(24, e.a, e.b);
        p32 = mulw(32, e.a, e.b);
        chk("w4_prod", 64'(x4_p), p4);
        chk("w4_msb", 64'(x4_m), 64'(p4[7]));
        chk("w24_prod", 64'(x24_p), p24);
        chk("w24_msb", 64'(x24_m), 64'(p24[47]));
        chk("w32_prod", x32_p, p32);
        chk("w32_msb", 64'(x32_m), 64'(p32[63]));
        chk("wx_tag", 64'({x4_t, x24_t, x32_t}), 64'({e.t, e.t, e.t}));
      end
      if (x_iv) begin
        chk("wx_ready", 64'({x4_ir, x24_ir, x32_ir}), 64'(3'b111));
        e.a = x_a; e.b = x_b; e.t = x_tag; e.acc = cyc;
        xq.push_back(e);
      end
    end
  end

  initial begin
    bit seen_block;
    int k, n0;
    rst_n = 0; m_flush = 0; m_iv = 0; m_a = 0; m_b = 0; m_tag = 0; m_or = 1;
    x_iv = 0; x_a = 0; x_b = 0; x_tag = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(m_ov), 64'd0);
    chk("rst_prod", 64'(m_prod), 64'd0);
    chk("rst_msb", 64'(m_msb), 64'd0);
    chk("rst_tag", 64'(m_otag), 64'd0);
    chk("rst_ready", 64'(m_ir), 64'd1);
    rst_n = 1;

    // Two back-to-back ops, unstalled.
    m_iv = 1; m_a = 11'h7FF; m_b = 11'h7FF; m_tag = 4'h3;
    step();
    m_a = 11'h400; m_b = 11'h400; m_tag = 4'h5;
    step();
    m_iv = 0;
    chk("d1_valid", 64'(m_ov), 64'd1);
    chk("d1_prod", 64'(m_prod), 64'h3FF001);
    chk("d1_msb", 64'(m_msb), 64'd1);
    chk("d1_tag", 64'(m_otag), 64'h3);
    step();
    chk("d2_prod", 64'(m_prod), 64'h100000);
    chk("d2_msb", 64'(m_msb), 64'd0);
    chk("d2_tag", 64'(m_otag), 64'h5);
    step();
    chk("d2_drained", 64'(m_ov), 64'd0);

    // Back-pressure: 5 ops, output stalled for cycles 3..7.
    k = 0; seen_block = 0; n0 = n_out;
    for (int c = 0; c < 20; c++) begin
      m_or = !(c >= 3 && c <= 7);
      m_iv = (k < 5);
      m_a = 11'(150 * k + 7);
      m_b = 11'(2000 - 37 * k);
      m_tag = 4'(k);
      @(negedge clk);
      if (m_iv && m_ir) k++;
      if (!m_ir) seen_block = 1;
      step();
    end
    m_iv = 0; m_or = 1;
    chk("bp_blocked", 64'(seen_block), 64'd1);
    chk("bp_issued", 64'(k), 64'd5);
    chk("bp_count", 64'(n_out - n0), 64'd5);

    // Flush with both stages full.
    m_iv = 1; m_a = 11'h123; m_b = 11'h456; m_tag = 4'h6;
    step();
    m_a = 11'h0AB; m_b = 11'h0CD; m_tag = 4'h7;
    step();
    m_iv = 0; m_or = 0; m_flush = 1;
    chk("fl_full", 64'(m_ov), 64'd1);
    step();
    m_flush = 0;
    chk("fl_valid", 64'(m_ov), 64'd0);
    chk("fl_ready", 64'(m_ir), 64'd1);
    m_or = 1; m_iv = 1; m_a = 11'h7FF; m_b = 11'h001; m_tag = 4'h9;
    step();
    m_iv = 0;
    chk("fl_lat1", 64'(m_ov), 64'd0);
    step();
    chk("fl_lat2", 64'(m_ov), 64'd1);
    chk("fl_prod", 64'(m_prod), 64'h7FF);
    chk("fl_tag", 64'(m_otag), 64'h9);

    // Asynchronous reset with both stages full and stalled.
    step();
    m_or = 0; m_iv = 1; m_a = 11'h3AA; m_b = 11'h2BB; m_tag = 4'hA;
    step();
    m_tag = 4'hB;
    step();
    m_iv = 0;
    chk("ar_full", 64'(m_ov), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("ar_valid", 64'(m_ov), 64'd0);
    chk("ar_prod", 64'(m_prod), 64'd0);
    chk("ar_ready", 64'(m_ir), 64'd1);
    step();
    rst_n = 1; m_or = 1;

    // Random traffic with random back-pressure.
    for (int i = 0; i < 300; i++) begin
      m_iv = ($urandom_range(0, 3) != 0);
      m_or = ($urandom_range(0, 2) != 0);
      m_a = 11'($urandom_range(0, 2047));
      m_b = 11'($urandom_range(0, 2047));
      m_tag = 4'($urandom_range(0, 15));
      step();
    end
    m_iv = 0; m_or = 1;
    repeat (4) step();
    chk("main_drain", 64'(mq.size()), 64'd0);

    // Other widths, directed then random.
    x_iv = 1; x_a = 32'hFFFFFF; x_b = 32'hFFFFFF; x_tag = 4'h1;
    step();
    x_a = 32'h800000; x_b = 32'h1; x_tag = 4'h2;
    step();
    chk("w24_p1", 64'(x24_p), 64'hFFFFFE000001);
    chk("w24_m1", 64'(x24_m), 64'd1);
    chk("w4_p1", 64'(x4_p), 64'hE1);
    x_a = 32'hFFFFFFFF; x_b = 32'hFFFFFFFF; x_tag = 4'h3;
    step();
    chk("w24_p2", 64'(x24_p), 64'h800000);
    chk("w24_m2", 64'(x24_m), 64'd0);
    x_a = 32'h0; x_b = 32'hABC; x_tag = 4'h4;
    step();
    chk("w32_p3", x32_p, 64'hFFFFFFFE00000001);
    chk("w32_m3", 64'(x32_m), 64'd1);
    x_iv = 0;
    step();
    chk("w32_zero", x32_p, 64'd0);
    chk("w32_zmsb", 64'(x32_m), 64'd0);
    for (int i = 0; i < 300; i++) begin
      x_iv = ($urandom_range(0, 3) != 0);
      x_a = $urandom;
      x_b = $urandom;
      x_tag = 4'($urandom_range(0, 15));
      step();
    end
    x_iv = 0;
    repeat (4) step();
    chk("wx_drain", 64'(xq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dadda_mul_pipe.md
Name: dadda_mul_pipe

Overview:
- Parametrised, pipelined unsigned mantissa multiplier for the FP datapath; next generation of the fixed 11-bit Dadda multiplier.
- Supports any operand width: WIDTH=11 for fp16, 24 for fp32.
- Stage 1 registers the carry-save pair produced by a generated Dadda reduction tree. Stage 2 registers the final Kogge-Stone sum.
- Valid/ready handshake with back-pressure, a sideband tag, a normalisation flag and a synchronous flush. Sits between the exponent/sign unpack stage and the FP normaliser.

Parameters:
- WIDTH, 11, operand width in bits; legal range 4..32.
- TAG_W, 4, sideband tag width, carried unchanged alongside each operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all in-flight operations.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  block accepts operands this cycle.
- in_a_i  in  WIDTH  multiplicand, unsigned.
- in_b_i  in  WIDTH  multiplier, unsigned.
- in_tag_i  in  TAG_W  sideband tag.
- out_valid_o  out  1  product valid.
- out_ready_i  in  1  downstream accepts product.
- out_prod_o  out  2*WIDTH  product in_a*in_b.
- out_msb_o  out  1  equals out_prod_o[2*WIDTH-1]; drives normaliser shift select.
- out_tag_o  out  TAG_W  tag of the operation on out_prod_o.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Both stage-valid bits v1, v2 clear to 0.
  - All data and tag registers clear to 0.
  - Outputs: out_valid_o=0, out_prod_o=0, out_msb_o=0, out_tag_o=0, in_ready_o=1.
- Reset mid-operation: all in-flight operations are discarded with no partial output.
- Stage 1 (S1): Dadda reduction of the WIDTH*WIDTH partial products into two rows, each 2*WIDTH-1 bits wide.
  - Row 0 carries bit 0 of the product.
  - Row 1 has bit 0 tied to 0.
  - On transfer, S1 registers row0, row1 and the tag, and sets v1.
- Stage 2 (S2): ksa with BITS=2*WIDTH-1 and cin=0 adds row0 and row1. Its sum plus carry-out gives the 2*WIDTH-bit product.
  - On transfer, S2 registers the product and tag, and sets v2.
- Advance rules (combinational):
  - adv2 = !v2 | out_ready_i
  - in_ready_o = !v1 | adv2
- S2 loads when adv2; on load, v2 <= v1.
- S1 loads when in_ready_o; on load, v1 <= in_valid_i.
- When a stage does not load, its data and tag registers hold their values.
- Data registers update only when the incoming valid is 1, so a bubble does not disturb the last product.
- Latency: 2 cycles. Operands accepted at edge N appear on out_valid_o after edge N+2 when unstalled.
- Throughput: 1 operation per cycle.
- Full stall (v1=v2=1, out_ready_i=0):
  - in_ready_o=0.
  - Outputs and S1 hold stable; no drop and no duplication.
- Simultaneous output consume and input accept at full: both stages shift and the new operand enters S1 in the same cycle.
- out_valid_o & !out_ready_i: out_prod_o and out_tag_o must remain stable until the transfer.
- flush_i=1:
  - At the next edge, v1 and v2 clear; data registers hold.
  - An input presented in the flush cycle is discarded. in_ready_o still follows the rule above, so upstream sees the transfer as accepted.
  - flush_i has priority over all loads.
- Arithmetic:
  - Exact unsigned product; no overflow is possible in 2*WIDTH bits.
  - Zero operands give 0 with out_msb_o=0.
- Boundary widths:
  - Reduction heights sequence d_j (2,3,4,6,9,13,19,28...) is truncated to the largest d_j < WIDTH.
  - WIDTH=4 and WIDTH=32 must elaborate and compute correctly.

Decomposition:
- Package mul_pkg holds:
  - FP16_MANT_W=11 and FP32_MANT_W=24.
  - Function dadda_stages(width) returning the stage count.
  - Function dadda_height(j) returning the d_j sequence.
- Sub-module dadda_reduce #(WIDTH): purely combinational, a,b -> row0,row1 (2*WIDTH-1 bits). Generate-loop form replacing hand-enumerated wires.
- Existing ksa #(BITS) is reused unchanged for the final add.
- Top level contains only the handshake, pipeline registers and flush.

Test Plan:
- WIDTH=11, unstalled:
  - 0x7FF*0x7FF, tag 0x3 -> out_prod_o=0x3FF001, out_msb_o=1, tag 0x3, two cycles after acceptance.
  - Next cycle 0x400*0x400 -> 0x100000, out_msb_o=0.
- WIDTH=24: 0xFFFFFF*0xFFFFFF -> 0xFFFFFE000001, msb=1; 0x800000*0x000001 -> 0x000000800000, msb=0.
- Back-pressure: stream 5 ops (tags 0..4), out_ready_i=0 for cycles 3..7.
  - in_ready_o=0 once both stages are full; outputs hold stable throughout.
  - All 5 products emerge in order with no loss or duplication.
- Flush: 2 ops in flight, assert flush_i for one cycle -> out_valid_o=0 next cycle; the next op issued completes normally with latency 2.
- Reset: assert rst_n=0 asynchronously with both stages full -> out_valid_o=0 immediately (before the next edge), out_prod_o=0, in_ready_o=1.
- Random: 10k random pairs each at WIDTH=4, 11, 24, 32, with random out_ready_i. Every product equals the reference a*b and tags are in order.
